// File: rtl/shift_engine.sv
// shift_engine
//   Multi-cycle barrel-less shifter. A request captures one operand, a mode
//   and a distance, then moves the operand one bit per clock until the
//   distance is used up. The result and its flags are published together on
//   the cycle that Done pulses.
//
// Ports
//   CLK        rising-edge clock
//   RST_n      asynchronous active-low reset
//   Start      request, sampled only while idle
//   Cancel     synchronous abort of a shift in progress (wins over Start)
//   A, B       operands; Op_Sel picks B when high
//   Mode       000 LSR, 001 LSL, 010 ASR, 011 ROR, 100 ROL, others pass-through
//   Amount     shift distance, clamped to WIDTH-1
//   Busy       high whenever the engine is not idle
//   Done       one-cycle completion pulse
//   SHIFT_OUT  registered result
//   Carry_Out  registered last bit moved out of the register
//   Zero_Flag  registered SHIFT_OUT == 0
module shift_engine #(
    parameter  int WIDTH = 8,
    localparam int AMT_W = $clog2(WIDTH)
) (
    input  logic             CLK,
    input  logic             RST_n,
    input  logic             Start,
    input  logic             Cancel,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Op_Sel,
    input  logic [2:0]       Mode,
    input  logic [AMT_W-1:0] Amount,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] SHIFT_OUT,
    output logic             Carry_Out,
    output logic             Zero_Flag
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [AMT_W-1:0] MAX_AMT = AMT_W'(WIDTH - 1);
    localparam logic [AMT_W-1:0] ONE_AMT = AMT_W'(1);

    state_t           state;
    logic [WIDTH-1:0] work;
    logic [2:0]       mode_r;
    logic [AMT_W-1:0] cnt;

    logic [WIDTH-1:0] operand;
    logic [AMT_W-1:0] amt_c;
    logic             mode_legal;
    logic [WIDTH-1:0] step_val;
    logic             step_bit;

    assign operand    = Op_Sel ? B : A;
    assign mode_legal = !(Mode[2] && (Mode[1:0] != 2'b00));

    // Distances beyond WIDTH-1 only exist when WIDTH is not a power of two;
    // the comparison is elaborated only in that case.
    generate
        if ((1 << AMT_W) > WIDTH) begin : g_clamp
            assign amt_c = (Amount > MAX_AMT) ? MAX_AMT : Amount;
        end else begin : g_noclamp
            assign amt_c = Amount;
        end
    endgenerate

    // One-bit move of the work register for the captured mode, together with
    // the bit that leaves the register on that move.
    always_comb begin
        step_val = work;
        step_bit = 1'b0;
        case (mode_r)
            3'b000: begin
                step_val = {1'b0, work[WIDTH-1:1]};
                step_bit = work[0];
            end
            3'b001: begin
                step_val = {work[WIDTH-2:0], 1'b0};
                step_bit = work[WIDTH-1];
            end
            3'b010: begin
                step_val = {work[WIDTH-1], work[WIDTH-1:1]};
                step_bit = work[0];
            end
            3'b011: begin
                step_val = {work[0], work[WIDTH-1:1]};
                step_bit = work[0];
            end
            3'b100: begin
                step_val = {work[WIDTH-2:0], work[WIDTH-1]};
                step_bit = work[WIDTH-1];
            end
            default: begin
                step_val = work;
                step_bit = 1'b0;
            end
        endcase
    end

    // Control FSM with registered Busy/Done. Outputs change only on the edge
    // that enters DONE, so a cancelled operation leaves the old result intact.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state     <= IDLE;
            work      <= '0;
            mode_r    <= '0;
            cnt       <= '0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            SHIFT_OUT <= '0;
            Carry_Out <= 1'b0;
            Zero_Flag <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start && !Cancel) begin
                        work   <= operand;
                        mode_r <= Mode;
                        cnt    <= amt_c;
                        Busy   <= 1'b1;
                        if ((amt_c != '0) && mode_legal) begin
                            state <= SHIFT;
                        end else begin
                            // Zero distance or pass-through completes at once.
                            state     <= DONE;
                            Done      <= 1'b1;
                            SHIFT_OUT <= operand;
                            Carry_Out <= 1'b0;
                            Zero_Flag <= (operand == '0);
                        end
                    end
                end
                SHIFT: begin
                    if (Cancel) begin
                        state <= IDLE;
                        Busy  <= 1'b0;
                    end else begin
                        work <= step_val;
                        cnt  <= cnt - ONE_AMT;
                        if (cnt == ONE_AMT) begin
                            state     <= DONE;
                            Done      <= 1'b1;
                            SHIFT_OUT <= step_val;
                            Carry_Out <= step_bit;
                            Zero_Flag <= (step_val == '0);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                    Done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                    Done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_engine.sv
// tb_shift_engine
//   Self-checking bench for shift_engine at WIDTH=8. A cycle-level reference
//   model counts down the remaining busy cycles of each accepted request and
//   computes the result with whole-word arithmetic shifts and rotates. A
//   compare process checks every DUT output against the model each cycle;
//   directed cases pin specific results with literal values, and a random
//   phase drives arbitrary traffic including Cancel.
module tb_shift_engine;

    localparam int W = 8;

    logic         CLK = 1'b0;
    logic         RST_n = 1'b0;
    logic         Start = 1'b0;
    logic         Cancel = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         Op_Sel = 1'b0;
    logic [2:0]   Mode = '0;
    logic [2:0]   Amount = '0;
    logic         Busy;
    logic         Done;
    logic [W-1:0] SHIFT_OUT;
    logic         Carry_Out;
    logic         Zero_Flag;

    int errors = 0;
    int checks = 0;
    bit finished = 1'b0;

    // Reference model state: cycles left until idle, and published outputs.
    int           mLeft = 0;
    logic [W-1:0] mOut = '0;
    logic         mCarry = 1'b0;
    logic         mZero = 1'b0;
    logic [W-1:0] mPendOut = '0;
    logic         mPendCarry = 1'b0;

    shift_engine #(.WIDTH(W)) dut (
        .CLK       (CLK),
        .RST_n     (RST_n),
        .Start     (Start),
        .Cancel    (Cancel),
        .A         (A),
        .B         (B),
        .Op_Sel    (Op_Sel),
        .Mode      (Mode),
        .Amount    (Amount),
        .Busy      (Busy),
        .Done      (Done),
        .SHIFT_OUT (SHIFT_OUT),
        .Carry_Out (Carry_Out),
        .Zero_Flag (Zero_Flag)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // Whole-word result of shifting x by n (n >= 1) in mode m, plus the
    // last bit to leave the word.
    function automatic void refShift(input logic [W-1:0] x, input int m,
                                     input int n, output logic [W-1:0] r,
                                     output logic c);
        r = x;
        c = 1'b0;
        case (m)
            0: begin r = x >> n;                     c = x[n-1]; end
            1: begin r = x << n;                     c = x[W-n]; end
            2: begin r = W'($signed(x) >>> n);       c = x[n-1]; end
            3: begin r = (x >> n) | (x << (W - n));  c = r[W-1]; end
            4: begin r = (x << n) | (x >> (W - n));  c = r[0];   end
            default: begin r = x; c = 1'b0; end
        endcase
    endfunction

    // Reference model: tracks the request through its Amount+1 busy cycles.
    always @(posedge CLK or negedge RST_n) begin
        logic [W-1:0] op;
        logic [W-1:0] r;
        logic         c;
        if (!RST_n) begin
            mLeft  = 0;
            mOut   = '0;
            mCarry = 1'b0;
            mZero  = 1'b0;
        end else if (mLeft == 0) begin
            if (Start && !Cancel) begin
                op = Op_Sel ? B : A;
                if (Amount == 0 || Mode > 3'd4) begin
                    mLeft  = 1;
                    mOut   = op;
                    mCarry = 1'b0;
                    mZero  = (op == 0);
                end else begin
                    refShift(op, int'(Mode), int'(Amount), r, c);
                    mPendOut   = r;
                    mPendCarry = c;
                    mLeft      = int'(Amount) + 1;
                end
            end
        end else if (mLeft == 1) begin
            mLeft = 0;
        end else if (Cancel) begin
            mLeft = 0;
        end else begin
            mLeft = mLeft - 1;
            if (mLeft == 1) begin
                mOut   = mPendOut;
                mCarry = mPendCarry;
                mZero  = (mPendOut == 0);
            end
        end
    end

    // Every-cycle comparison of DUT outputs against the model.
    always @(posedge CLK) begin
        #2;
        if (!finished) begin
            checkOutput("busy", 64'(Busy), 64'(mLeft != 0));
            checkOutput("done", 64'(Done), 64'(mLeft == 1));
            checkOutput("shift_out", 64'(SHIFT_OUT), 64'(mOut));
            checkOutput("carry", 64'(Carry_Out), 64'(mCarry));
            checkOutput("zero", 64'(Zero_Flag), 64'(mZero));
        end
    end

    // Waits for Done with a cycle bound; lat counts edges since the capture.
    task automatic waitDone(output int lat);
        lat = 1;
        while (!Done && lat < 20) begin
            @(negedge CLK);
            lat++;
        end
    endtask

    // Issues one request, then scrambles every request input so that only
    // the captured values can influence the result.
    task automatic applyStimulus(input logic [2:0] m, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic sel,
                                 input logic [2:0] amt, output int lat);
        @(negedge CLK);
        Mode = m; A = a; B = b; Op_Sel = sel; Amount = amt; Start = 1'b1;
        @(negedge CLK);
        Start  = 1'b0;
        A      = W'($urandom);
        B      = W'($urandom);
        Mode   = 3'($urandom);
        Amount = 3'($urandom);
        Op_Sel = 1'($urandom);
        waitDone(lat);
    endtask

    initial begin
        int  lat;
        bit  sawDone;

        repeat (2) @(negedge CLK);
        checkOutput("reset_busy", 64'(Busy), 64'd0);
        checkOutput("reset_out", 64'(SHIFT_OUT), 64'd0);
        RST_n = 1'b1;

        // LSR 0xB5 by 3
        applyStimulus(3'b000, 8'hB5, 8'h00, 1'b0, 3'd3, lat);
        checkOutput("lsr_latency", 64'(lat), 64'd4);
        checkOutput("lsr_out", 64'(SHIFT_OUT), 64'h16);
        checkOutput("lsr_carry", 64'(Carry_Out), 64'd1);
        checkOutput("lsr_zero", 64'(Zero_Flag), 64'd0);
        checkOutput("model_lsr", 64'(mOut), 64'h16);
        @(negedge CLK);
        checkOutput("lsr_busy_after", 64'(Busy), 64'd0);
        checkOutput("lsr_done_after", 64'(Done), 64'd0);

        // ASR 0x90 from B by 2, A scrambled mid-operation
        applyStimulus(3'b010, 8'h11, 8'h90, 1'b1, 3'd2, lat);
        checkOutput("asr_latency", 64'(lat), 64'd3);
        checkOutput("asr_out", 64'(SHIFT_OUT), 64'hE4);
        checkOutput("asr_carry", 64'(Carry_Out), 64'd0);
        checkOutput("model_asr", 64'(mOut), 64'hE4);

        // ROL 0x81 by 1, then LSL 0x80 by 1
        applyStimulus(3'b100, 8'h81, 8'h00, 1'b0, 3'd1, lat);
        checkOutput("rol_out", 64'(SHIFT_OUT), 64'h03);
        checkOutput("rol_carry", 64'(Carry_Out), 64'd1);
        applyStimulus(3'b001, 8'h80, 8'h00, 1'b0, 3'd1, lat);
        checkOutput("lsl_out", 64'(SHIFT_OUT), 64'h00);
        checkOutput("lsl_carry", 64'(Carry_Out), 64'd1);
        checkOutput("lsl_zero", 64'(Zero_Flag), 64'd1);

        // Zero distance and pass-through complete in one edge
        applyStimulus(3'b000, 8'h5A, 8'h00, 1'b0, 3'd0, lat);
        checkOutput("amt0_latency", 64'(lat), 64'd1);
        checkOutput("amt0_out", 64'(SHIFT_OUT), 64'h5A);
        checkOutput("amt0_carry", 64'(Carry_Out), 64'd0);
        applyStimulus(3'b110, 8'h5A, 8'h00, 1'b0, 3'd5, lat);
        checkOutput("pass_latency", 64'(lat), 64'd1);
        checkOutput("pass_out", 64'(SHIFT_OUT), 64'h5A);
        checkOutput("pass_carry", 64'(Carry_Out), 64'd0);

        // LSR by 7 cancelled on its third cycle
        @(negedge CLK);
        Mode = 3'b000; A = 8'hFF; Op_Sel = 1'b0; Amount = 3'd7; Start = 1'b1;
        @(negedge CLK);
        Start = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        Cancel = 1'b1;
        @(negedge CLK);
        Cancel = 1'b0;
        checkOutput("cancel_busy", 64'(Busy), 64'd0);
        checkOutput("cancel_out", 64'(SHIFT_OUT), 64'h5A);
        sawDone = 1'b0;
        repeat (8) begin
            if (Done) sawDone = 1'b1;
            @(negedge CLK);
        end
        checkOutput("cancel_no_done", 64'(sawDone), 64'd0);

        // Reset during SHIFT, then ROR accepted on the first edge after release
        Mode = 3'b000; A = 8'hF0; Amount = 3'd5; Start = 1'b1;
        @(negedge CLK);
        Start = 1'b0;
        @(negedge CLK);
        #2 RST_n = 1'b0;
        #1;
        checkOutput("rst_busy", 64'(Busy), 64'd0);
        checkOutput("rst_done", 64'(Done), 64'd0);
        checkOutput("rst_out", 64'(SHIFT_OUT), 64'd0);
        checkOutput("rst_carry", 64'(Carry_Out), 64'd0);
        checkOutput("rst_zero", 64'(Zero_Flag), 64'd0);
        @(negedge CLK);
        @(negedge CLK);
        RST_n = 1'b1;
        Mode = 3'b011; A = 8'h01; Op_Sel = 1'b0; Amount = 3'd1; Start = 1'b1;
        @(negedge CLK);
        Start = 1'b0;
        waitDone(lat);
        checkOutput("ror_latency", 64'(lat), 64'd2);
        checkOutput("ror_out", 64'(SHIFT_OUT), 64'h80);
        checkOutput("ror_carry", 64'(Carry_Out), 64'd1);

        // Random traffic, including Start during busy and Cancel in every state
        repeat (3000) begin
            @(negedge CLK);
            A      = W'($urandom);
            B      = W'($urandom);
            Op_Sel = 1'($urandom);
            Mode   = 3'($urandom);
            Amount = 3'($urandom);
            Start  = ($urandom_range(0, 2) == 0);
            Cancel = ($urandom_range(0, 15) == 0);
        end
        @(negedge CLK);
        Start  = 1'b0;
        Cancel = 1'b0;
        repeat (12) @(negedge CLK);

        finished = 1'b1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/shift_engine.md
SHIFT_ENGINE -- requirements
Module: shift_engine

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, operand and result width in bits (legal: 2..64).
REQ-002 The block SHALL have derived localparam AMT_W = clog2(WIDTH), shift-amount width.
REQ-003 The block SHALL have port CLK  input  1  clock; all state updates on rising edge.
REQ-004 The block SHALL have port RST_n  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port Start  input  1  request; sampled only while Busy=0.
REQ-006 The block SHALL have port Cancel  input  1  synchronous abort of the current operation.
REQ-007 The block SHALL have port A  input  WIDTH  operand 0.
REQ-008 The block SHALL have port B  input  WIDTH  operand 1.
REQ-009 The block SHALL have port Op_Sel  input  1  operand select: 0=A, 1=B.
REQ-010 The block SHALL have port Mode  input  3  000 LSR, 001 LSL, 010 ASR, 011 ROR, 100 ROL, 101-111 pass-through.
REQ-011 The block SHALL have port Amount  input  AMT_W  shift distance, 0..WIDTH-1.
REQ-012 The block SHALL have port Busy  output  1  high whenever the FSM is not IDLE.
REQ-013 The block SHALL have port Done  output  1  one-cycle completion pulse.
REQ-014 The block SHALL have port SHIFT_OUT  output  WIDTH  registered result.
REQ-015 The block SHALL have port Carry_Out  output  1  registered last bit shifted or rotated out.
REQ-016 The block SHALL have port Zero_Flag  output  1  registered flag, high when SHIFT_OUT==0.

Function
REQ-017 The FSM SHALL have the states IDLE, SHIFT and DONE.
REQ-018 On an edge in IDLE with Start=1, the block SHALL capture the selected operand into a work register, Mode into a mode register, and Amount into a down-counter.
REQ-019 On that capture edge, the FSM SHALL go to SHIFT if Amount!=0 and Mode is legal, otherwise to DONE.
REQ-020 In SHIFT, each edge SHALL move the work register by exactly 1 bit per Mode and decrement the counter.
REQ-021 In SHIFT, when the counter equals 1 at an edge, that edge SHALL perform the final shift and go to DONE.
REQ-022 The bit-move rules per Mode SHALL be:
- LSR: shift right, zero-fill MSB.
- LSL: shift left, zero-fill LSB.
- ASR: shift right, replicate MSB.
- ROR/ROL: rotate, with the vacated bit taken from the opposite end.
REQ-023 Carry_Out SHALL be the bit leaving the register on the final step: bit0 for LSR/ASR/ROR, bit WIDTH-1 for LSL/ROL; it SHALL be 0 when Amount=0 or in pass-through.
REQ-024 SHIFT_OUT, Carry_Out and Zero_Flag SHALL update only on the edge that enters DONE, and SHALL hold until the next completion.
REQ-025 Done SHALL be high for exactly the one cycle spent in DONE; the next edge SHALL return the FSM to IDLE.
REQ-026 Latency SHALL be Amount+1 edges from the Start sample to Done high, and 1 edge when Amount=0 or in pass-through.
REQ-027 Start while Busy=1, including the DONE cycle, SHALL be ignored with no queuing.
REQ-028 A, B, Op_Sel, Mode and Amount changing after the capture edge SHALL NOT affect the operation in flight.
REQ-029 Cancel=1 in SHIFT SHALL force IDLE on the next edge, with no Done pulse and no output update.
REQ-030 Cancel in IDLE SHALL have no effect.
REQ-031 Cancel in DONE SHALL have no effect, so the completed result stands.
REQ-032 Cancel=1 and Start=1 together in IDLE SHALL give Cancel priority, and no capture SHALL occur.
REQ-033 Amount>=WIDTH is illegal, is not reachable when WIDTH is a power of two, and SHALL be clamped to WIDTH-1.

Reset
REQ-034 While RST_n=0, the block SHALL immediately force state IDLE, counter 0, work register 0, SHIFT_OUT=0, Carry_Out=0, Zero_Flag=0, Done=0 and Busy=0.
REQ-035 Reset asserted mid-operation SHALL discard the operation, and no Done SHALL follow its release.
REQ-036 After release, the first Start SHALL be accepted on the first rising edge at which RST_n=1.

Verification (WIDTH=8)
REQ-037 The bench SHALL cover: LSR, A=0xB5, Op_Sel=0, Amount=3 -> Busy high 4 cycles, Done on the 4th edge, SHIFT_OUT=0x16, Carry_Out=1, Zero_Flag=0.
REQ-038 The bench SHALL cover: ASR, B=0x90, Op_Sel=1, Amount=2 -> SHIFT_OUT=0xE4, Carry_Out=0, and A changed mid-op has no effect.
REQ-039 The bench SHALL cover: ROL, A=0x81, Amount=1 -> SHIFT_OUT=0x03, Carry_Out=1; then LSL, A=0x80, Amount=1 -> SHIFT_OUT=0x00, Zero_Flag=1, Carry_Out=1.
REQ-040 The bench SHALL cover: Amount=0 or Mode=110 with A=0x5A -> Done 1 edge after Start, SHIFT_OUT=0x5A, Carry_Out=0.
REQ-041 The bench SHALL cover: LSR, Amount=7, Cancel pulsed on cycle 3 -> Busy low next edge, no Done, SHIFT_OUT keeps its prior value.
REQ-042 The bench SHALL cover: RST_n low during SHIFT -> all outputs 0 immediately; then Start with ROR, A=0x01, Amount=1 -> SHIFT_OUT=0x80, Carry_Out=1.
